// File: rtl/eta2_adder_pipe.sv
// eta2_adder_pipe: two-stage valid/ready ETA-II (error-tolerant type-II) adder with per-transaction exact mode.
// Optional error monitor (err_o, err_cnt_o) is built when ETA2_ERR_MON_EN is defined.
module eta2_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int BLK_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic             exact_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   result_o
`ifdef ETA2_ERR_MON_EN
  ,
  output logic             err_o,
  output logic [15:0]      err_cnt_o
`endif
);

  localparam int NBLK = (BLK_W >= 1) ? (WIDTH / BLK_W) : 1;

  generate
    if (BLK_W < 1) begin : g_bad_blk_w
      $error("eta2_adder_pipe: BLK_W must be >= 1");
    end else if ((WIDTH % BLK_W) != 0) begin : g_bad_width
      $error("eta2_adder_pipe: WIDTH must be a multiple of BLK_W");
    end
  endgenerate

  // One BLK_W-bit block add; bit BLK_W is the block carry-out.
  function automatic logic [BLK_W:0] blk_add(
    input logic [BLK_W-1:0] a,
    input logic [BLK_W-1:0] b,
    input logic             c
  );
    return {1'b0, a} + {1'b0, b} + {{BLK_W{1'b0}}, c};
  endfunction

  logic             v1_r;
  logic             v2_r;
  logic             ex1_r;
  logic [WIDTH-1:0] a1_r;
  logic [WIDTH-1:0] b1_r;
  logic [NBLK-1:0]  gen_s;
  logic [NBLK-1:0]  gen1_r;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   result_r;
  logic             adv1_s;
  logic             adv2_s;

  // Pipeline advance: a stage moves when it is empty or the stage after it moves.
  always_comb begin
    adv2_s = !v2_r || out_ready_i;
    adv1_s = !v1_r || adv2_s;
  end

  assign in_ready_o  = adv1_s;
  assign out_valid_o = v2_r;
  assign result_o    = result_r;

  // Per-block generate: carry-out of each block assuming zero carry-in.
  always_comb begin
    logic [BLK_W:0] blk;
    gen_s = '0;
    blk   = '0;
    for (int k = 0; k < NBLK; k++) begin
      blk      = blk_add(add1_i[k*BLK_W +: BLK_W], add2_i[k*BLK_W +: BLK_W], 1'b0);
      gen_s[k] = blk[BLK_W];
    end
  end

  // Stage 1: capture operands, mode and block generates.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v1_r   <= 1'b0;
      ex1_r  <= 1'b0;
      a1_r   <= '0;
      b1_r   <= '0;
      gen1_r <= '0;
    end else if (adv1_s) begin
      v1_r <= in_valid_i;
      if (in_valid_i) begin
        ex1_r  <= exact_i;
        a1_r   <= add1_i;
        b1_r   <= add2_i;
        gen1_r <= gen_s;
      end
    end
  end

  // Block sums: exact mode ripples the real carry, approximate mode uses the previous block's generate.
  always_comb begin
    logic [BLK_W:0] blk;
    logic           ripple;
    logic           prev_g;
    logic           cin;
    sum_s  = '0;
    blk    = '0;
    ripple = 1'b0;
    prev_g = 1'b0;
    cin    = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      cin    = ex1_r ? ripple : prev_g;
      blk    = blk_add(a1_r[k*BLK_W +: BLK_W], b1_r[k*BLK_W +: BLK_W], cin);
      sum_s[k*BLK_W +: BLK_W] = blk[BLK_W-1:0];
      ripple = blk[BLK_W];
      prev_g = gen1_r[k];
    end
    sum_s[WIDTH] = ripple;
  end

  // Stage 2: register the result; the result is held while the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v2_r     <= 1'b0;
      result_r <= '0;
    end else if (adv2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        result_r <= sum_s;
      end
    end
  end

`ifdef ETA2_ERR_MON_EN
  logic [WIDTH:0] ref_s;
  logic           err_s;
  logic           err_r;
  logic [15:0]    err_cnt_r;

  // Exact reference sum; a mismatch can only occur in approximate mode.
  always_comb begin
    ref_s = {1'b0, a1_r} + {1'b0, b1_r};
    err_s = !ex1_r && (sum_s != ref_s);
  end

  // Error flag travels with the result it describes.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_r <= 1'b0;
    end else if (adv2_s && v1_r) begin
      err_r <= err_s;
    end
  end

  // Saturating count of erroneous results actually handed downstream.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_cnt_r <= 16'h0000;
    end else if (v2_r && out_ready_i && err_r && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'h0001;
    end
  end

  assign err_o     = err_r;
  assign err_cnt_o = err_cnt_r;
`endif

endmodule

// File: tb/tb_eta2_adder_pipe.sv
// Self-checking bench for eta2_adder_pipe: arithmetic reference model + scoreboard, directed vectors.
// Error-monitor checks are compiled in when ETA2_ERR_MON_EN is defined.
module tb_eta2_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        exact;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] add1;
  logic [31:0] add2;
  logic [32:0] result;
`ifdef ETA2_ERR_MON_EN
  logic        err;
  logic [15:0] err_cnt;
  logic        s_err;
  logic [15:0] s_err_cnt;
`endif

  logic        s_in_valid;
  logic        s_in_ready;
  logic        s_exact;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [15:0] s_add1;
  logic [15:0] s_add2;
  logic [16:0] s_result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [32:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];

  eta2_adder_pipe #(.WIDTH(32), .BLK_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .add1_i(add1), .add2_i(add2), .exact_i(exact),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result)
`ifdef ETA2_ERR_MON_EN
    , .err_o(err), .err_cnt_o(err_cnt)
`endif
  );

  eta2_adder_pipe #(.WIDTH(16), .BLK_W(8)) dut16 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .add1_i(s_add1), .add2_i(s_add2), .exact_i(s_exact),
    .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
    .result_o(s_result)
`ifdef ETA2_ERR_MON_EN
    , .err_o(s_err), .err_cnt_o(s_err_cnt)
`endif
  );

  always @(posedge clk) cyc++;

  // Reference: split into blocks with plain integer arithmetic; each block's carry-in is
  // recomputed from the previous block's operands alone.
  function automatic logic [32:0] model_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic ex, input int w, input int bw);
    longint unsigned m, wm, res, s, c, ak, bk, ap, bp;
    m   = (64'd1 << bw) - 64'd1;
    wm  = (64'd1 << w) - 64'd1;
    res = 64'd0;
    if (ex) begin
      res = (64'(a) & wm) + (64'(b) & wm);
    end else begin
      for (int k = 0; k < w / bw; k++) begin
        ak = (64'(a) >> (k * bw)) & m;
        bk = (64'(b) >> (k * bw)) & m;
        c  = 64'd0;
        if (k > 0) begin
          ap = (64'(a) >> ((k - 1) * bw)) & m;
          bp = (64'(b) >> ((k - 1) * bw)) & m;
          c  = (ap + bp) >> bw;
        end
        s   = ak + bk + c;
        res = res | ((s & m) << (k * bw));
        if (k == w / bw - 1) res = res | ((s >> bw) << w);
      end
    end
    return res[32:0];
  endfunction

  function automatic exp_t model_entry(input logic [31:0] a, input logic [31:0] b, input logic ex);
    exp_t e;
    logic [32:0] ap, xs;
    ap    = model_add(a, b, 1'b0, 32, 4);
    xs    = model_add(a, b, 1'b1, 32, 4);
    e.res = ex ? xs : ap;
    e.err = !ex && (ap != xs);
    return e;
  endfunction

  task automatic chk(input string name, input logic [32:0] got, input logic [32:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Scoreboard compare, stall stability and error-count tracking, once per cycle on the falling edge.
  logic        prev_hold = 1'b0;
  logic [32:0] prev_res  = '0;
  int          model_cnt = 0;
  always @(negedge clk) begin : cmp
    exp_t e;
    if (prev_hold) begin
      chk("stall_valid", {32'd0, out_valid}, 33'd1);
      chk("stall_result", result, prev_res);
    end
`ifdef ETA2_ERR_MON_EN
    chk("err_cnt", {17'd0, err_cnt}, {17'd0, model_cnt[15:0]});
`endif
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h, required no output", result);
      end else begin
        e = sb.pop_front();
        chk("sb_result", result, e.res);
`ifdef ETA2_ERR_MON_EN
        chk("sb_err", {32'd0, err}, {32'd0, e.err});
`endif
        if (e.err && model_cnt < 65535) model_cnt++;
      end
    end
    if (rst_n && in_valid && in_ready) sb.push_back(model_entry(add1, add2, exact));
    prev_hold = rst_n && out_valid && !out_ready;
    prev_res  = result;
    if (!rst_n) begin
      sb.delete();
      model_cnt = 0;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one transaction (caller is just after a rising edge) and hold it until accepted.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ex);
    int n;
    n        = 0;
    add1     = a;
    add2     = b;
    exact    = ex;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles, required acceptance");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [32:0] lit, input logic elit);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, {32'd0, out_valid}, 33'd1);
    chk(name, result, lit);
`ifdef ETA2_ERR_MON_EN
    chk({name, "_err"}, {32'd0, err}, {32'd0, elit});
`else
    if (elit === 1'bx) $display("note: unknown error flag for %s", name);
`endif
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_empty", 33'(sb.size()), 33'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    int c0;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; add1 = '0; add2 = '0; exact = 1'b0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_add1 = '0; s_add2 = '0; s_exact = 1'b0; s_out_ready = 1'b1;

    // Pin the reference model against hand-computed sums.
    chk("model_5555", model_add(32'h5555_5555, 32'hAAAA_AAAA, 1'b0, 32, 4), 33'h0_FFFF_FFFF);
    chk("model_ff_apx", model_add(32'h0000_00FF, 32'h0000_0001, 1'b0, 32, 4), 33'h0_0000_0000);
    chk("model_ff_ex", model_add(32'h0000_00FF, 32'h0000_0001, 1'b1, 32, 4), 33'h0_0000_0100);
    chk("model_max_apx", model_add(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32, 4), 33'h0_FFFF_FF00);
    chk("model_max_ex", model_add(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32, 4), 33'h1_0000_0000);
    chk("model_deaf", model_add(32'h0000_0001, 32'hDEAF_BEEF, 1'b0, 32, 4), 33'h0_DEAF_BEF0);
    chk("model_16_ff", model_add(32'h0000_00FF, 32'h0000_0001, 1'b0, 16, 8), 33'h0_0000_0100);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {32'd0, out_valid}, 33'd0);
    chk("rst_result", result, 33'd0);
    chk("rst_in_ready", {32'd0, in_ready}, 33'd1);

    sync(); send(32'h5555_5555, 32'hAAAA_AAAA, 1'b0); expect_out("apx_5555", 33'h0_FFFF_FFFF, 1'b0);
    sync(); send(32'h0000_00FF, 32'h0000_0001, 1'b0); expect_out("apx_ff", 33'h0_0000_0000, 1'b1);
    sync(); send(32'h0000_00FF, 32'h0000_0001, 1'b1); expect_out("ex_ff", 33'h0_0000_0100, 1'b0);
    sync(); send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0); expect_out("apx_max", 33'h0_FFFF_FF00, 1'b1);
    sync(); send(32'hFFFF_FFFF, 32'h0000_0001, 1'b1); expect_out("ex_max", 33'h1_0000_0000, 1'b0);
    sync(); send(32'h0000_0001, 32'hDEAF_BEEF, 1'b0); expect_out("apx_deaf", 33'h0_DEAF_BEF0, 1'b0);

    // Back-to-back stream with alternating mode: one acceptance per cycle.
    sync();
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      a = 32'h9E37_79B9 * (i + 1);
      b = 32'h7F4A_7C15 ^ (a << 3);
      send(a, b, i[0]);
    end
    chk("stream_cycles", 33'(cyc - c0), 33'd16);
    wait_drain();

    // Stall: three offers while the consumer is blocked for five cycles.
    sync();
    out_ready = 1'b0;
    fork
      begin
        send(32'h0000_00FF, 32'h0000_0001, 1'b0);
        send(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
        send(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", {32'd0, in_ready}, 33'd0);
        chk("stall_full_valid", {32'd0, out_valid}, 33'd1);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with two transactions in flight.
    sync();
    send(32'h0000_00FF, 32'h0000_0001, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {32'd0, out_valid}, 33'd0);
    chk("midrst_result", result, 33'd0);
    chk("midrst_in_ready", {32'd0, in_ready}, 33'd1);
`ifdef ETA2_ERR_MON_EN
    chk("midrst_err_cnt", {17'd0, err_cnt}, 33'd0);
`endif
    repeat (3) @(negedge clk);
    chk("midrst_no_stale", {32'd0, out_valid}, 33'd0);

    // 16-bit, 8-bit-block instance.
    sync();
    s_add1 = 16'h00FF; s_add2 = 16'h0001; s_exact = 1'b0; s_in_valid = 1'b1;
    @(negedge clk);
    chk("w16_in_ready", {32'd0, s_in_ready}, 33'd1);
    sync();
    s_in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!s_out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("w16_valid", {32'd0, s_out_valid}, 33'd1);
    chk("w16_ff_lit", {16'd0, s_result}, 33'h0_0000_0100);
    chk("w16_ff_model", {16'd0, s_result}, {16'd0, model_add(32'h0000_00FF, 32'h0000_0001, 1'b0, 16, 8)});
`ifdef ETA2_ERR_MON_EN
    chk("w16_err", {32'd0, s_err}, 33'd0);
`endif
    sync();
    s_add1 = 16'hFFFF; s_add2 = 16'h0001; s_exact = 1'b0; s_in_valid = 1'b1;
    sync();
    s_in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!s_out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("w16_max", {16'd0, s_result}, 33'h0_0001_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
